// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
// The stage is the master; the memory (or a model of it) is the slave.
interface mem_access_stage_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_WIDTH  = 16
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  mem_wdata;
    logic [MEM_WIDTH-1:0]  mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: performs loads/stores over a req/ack bus, stalls upstream while an
// access is outstanding, and drives the registered MEM/WB payload to writeback.
module mem_access_stage #(
    parameter int ALU_WIDTH  = 32,
    parameter int MEM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ALU_WIDTH+MEM_WIDTH-1:0] exmem_data_in,
    input  logic [2:0]                     reg_addr_in,
    input  logic [2:0]                     mem_ctrl_in,
    input  logic [1:0]                     wb_ctrl_in,
    output logic                           stall,
    mem_access_stage_if.master             mem,
    output logic [ALU_WIDTH-1:0]           memwb_alu_out,
    output logic [ALU_WIDTH-1:0]           memwb_load_out,
    output logic [2:0]                     memwb_reg_addr_out,
    output logic [1:0]                     memwb_wb_ctrl_out,
    output logic                           mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter value reached on the TIMEOUT-th ACCESS cycle (counter starts at 0).
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [ALU_WIDTH-1:0] alu;
    logic [MEM_WIDTH-1:0] store_data;
    logic                 is_rd;
    logic                 is_wr;

    assign alu        = exmem_data_in[ALU_WIDTH-1:0];
    assign store_data = exmem_data_in[ALU_WIDTH+MEM_WIDTH-1:ALU_WIDTH];
    assign is_rd      = mem_ctrl_in[0];
    assign is_wr      = mem_ctrl_in[1];

    state_t                state_reg, state_next;
    logic [7:0]            cnt_reg, cnt_next;
    logic                  req_reg, req_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [MEM_WIDTH-1:0]  wdata_reg, wdata_next;
    logic                  sign_reg, sign_next;
    logic [MEM_WIDTH-1:0]  rdata_reg, rdata_next;
    logic                  abort_reg, abort_next;
    logic [ALU_WIDTH-1:0]  held_alu_reg, held_alu_next;
    logic [2:0]            held_reg_addr_reg, held_reg_addr_next;
    logic [1:0]            held_wb_reg, held_wb_next;
    logic [ALU_WIDTH-1:0]  out_alu_reg, out_alu_next;
    logic [ALU_WIDTH-1:0]  out_load_reg, out_load_next;
    logic [2:0]            out_reg_addr_reg, out_reg_addr_next;
    logic [1:0]            out_wb_reg, out_wb_next;
    logic                  err_reg, err_next;
    logic                  stall_comb;
    logic [ALU_WIDTH-1:0]  load_ext;

    assign load_ext = {{(ALU_WIDTH-MEM_WIDTH){sign_reg & rdata_reg[MEM_WIDTH-1]}}, rdata_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            req_reg           <= 1'b0;
            we_reg            <= 1'b0;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            sign_reg          <= 1'b0;
            rdata_reg         <= '0;
            abort_reg         <= 1'b0;
            held_alu_reg      <= '0;
            held_reg_addr_reg <= '0;
            held_wb_reg       <= '0;
            out_alu_reg       <= '0;
            out_load_reg      <= '0;
            out_reg_addr_reg  <= '0;
            out_wb_reg        <= '0;
            err_reg           <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            req_reg           <= req_next;
            we_reg            <= we_next;
            addr_reg          <= addr_next;
            wdata_reg         <= wdata_next;
            sign_reg          <= sign_next;
            rdata_reg         <= rdata_next;
            abort_reg         <= abort_next;
            held_alu_reg      <= held_alu_next;
            held_reg_addr_reg <= held_reg_addr_next;
            held_wb_reg       <= held_wb_next;
            out_alu_reg       <= out_alu_next;
            out_load_reg      <= out_load_next;
            out_reg_addr_reg  <= out_reg_addr_next;
            out_wb_reg        <= out_wb_next;
            err_reg           <= err_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        req_next           = req_reg;
        we_next            = we_reg;
        addr_next          = addr_reg;
        wdata_next         = wdata_reg;
        sign_next          = sign_reg;
        rdata_next         = rdata_reg;
        abort_next         = abort_reg;
        held_alu_next      = held_alu_reg;
        held_reg_addr_next = held_reg_addr_reg;
        held_wb_next       = held_wb_reg;
        out_alu_next       = out_alu_reg;
        out_load_next      = out_load_reg;
        out_reg_addr_next  = out_reg_addr_reg;
        out_wb_next        = out_wb_reg;
        err_next           = err_reg;
        stall_comb         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (is_rd ^ is_wr) begin
                    // Launch the access and park the instruction until it retires.
                    stall_comb         = 1'b1;
                    state_next         = ACCESS;
                    req_next           = 1'b1;
                    we_next            = is_wr;
                    addr_next          = alu[ADDR_WIDTH-1:0];
                    wdata_next         = store_data;
                    sign_next          = mem_ctrl_in[2];
                    rdata_next         = '0;
                    cnt_next           = '0;
                    held_alu_next      = alu;
                    held_reg_addr_next = reg_addr_in;
                    held_wb_next       = wb_ctrl_in;
                    out_alu_next       = '0;
                    out_load_next      = '0;
                    out_reg_addr_next  = '0;
                    out_wb_next        = '0;
                end else begin
                    out_alu_next      = alu;
                    out_load_next     = '0;
                    out_reg_addr_next = reg_addr_in;
                    out_wb_next       = wb_ctrl_in;
                    if (is_rd && is_wr) begin
                        out_wb_next[0] = 1'b0;
                        err_next       = 1'b1;
                    end
                end
            end

            ACCESS: begin
                stall_comb = 1'b1;
                if (mem.mem_ack) begin
                    if (!we_reg) begin
                        rdata_next = mem.mem_rdata;
                    end
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    err_next   = 1'b1;
                    abort_next = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            RESP: begin
                out_alu_next      = held_alu_reg;
                out_load_next     = load_ext;
                out_reg_addr_next = held_reg_addr_reg;
                out_wb_next       = {held_wb_reg[1], held_wb_reg[0] & ~abort_reg};
                abort_next        = 1'b0;
                state_next        = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset also forces stall low, even if a memory op is sitting on the inputs.
    assign stall              = rst_n & stall_comb;
    assign mem.mem_req        = req_reg;
    assign mem.mem_we         = we_reg;
    assign mem.mem_addr       = addr_reg;
    assign mem.mem_wdata      = wdata_reg;
    assign memwb_alu_out      = out_alu_reg;
    assign memwb_load_out     = out_load_reg;
    assign memwb_reg_addr_out = out_reg_addr_reg;
    assign memwb_wb_ctrl_out  = out_wb_reg;
    assign mem_err            = err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts stall, bus
// activity and the MEM/WB payload per cycle; a memory responder answers requests.
module tb_mem_access_stage;

    localparam int TO = 4;
    localparam int K_ZERO = 0;
    localparam int K_BUB  = 1;
    localparam int K_REC  = 2;

    logic        clk;
    logic        rst_n;
    logic [47:0] exmem_data_in;
    logic [2:0]  reg_addr_in;
    logic [2:0]  mem_ctrl_in;
    logic [1:0]  wb_ctrl_in;
    logic        stall;
    logic [31:0] memwb_alu_out;
    logic [31:0] memwb_load_out;
    logic [2:0]  memwb_reg_addr_out;
    logic [1:0]  memwb_wb_ctrl_out;
    logic        mem_err;

    mem_access_stage_if #(.ADDR_WIDTH(16), .MEM_WIDTH(16)) bus ();

    mem_access_stage #(
        .ALU_WIDTH(32), .MEM_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exmem_data_in     (exmem_data_in),
        .reg_addr_in       (reg_addr_in),
        .mem_ctrl_in       (mem_ctrl_in),
        .wb_ctrl_in        (wb_ctrl_in),
        .stall             (stall),
        .mem               (bus.master),
        .memwb_alu_out     (memwb_alu_out),
        .memwb_load_out    (memwb_load_out),
        .memwb_reg_addr_out(memwb_reg_addr_out),
        .memwb_wb_ctrl_out (memwb_wb_ctrl_out),
        .mem_err           (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit          chk_en = 1'b1;
    int          exp_kind = K_ZERO;
    bit          exp_stall = 1'b0;
    bit          exp_req = 1'b0;
    bit          exp_err = 1'b0;
    logic [15:0] exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    bit          exp_we = 1'b0;
    logic [31:0] rec_alu = '0;
    logic [31:0] rec_load = '0;
    bit          rec_chk_load = 1'b0;
    logic [2:0]  rec_reg = '0;
    logic [1:0]  rec_wb = '0;

    // Responder controls
    bit          resp_en = 1'b0;
    int          resp_delay = 0;
    logic [15:0] resp_data = '0;
    bit          spur = 1'b0;
    int          wait_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks on ACCESS cycle resp_delay+1, never if resp_en is clear.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && resp_en) begin
                if (wait_cnt == resp_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = resp_data;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 16'h5A5A;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack   = spur && !bus.mem_req;
                bus.mem_rdata = 16'hDEAD;
                wait_cnt      = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 64'(stall), 64'(exp_stall));
            chk("mem_req", 64'(bus.mem_req), 64'(exp_req));
            chk("mem_err", 64'(mem_err), 64'(exp_err));
            if (bus.mem_req) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
                chk("mem_we", 64'(bus.mem_we), 64'(exp_we));
                if (exp_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
            end
            case (exp_kind)
                K_ZERO: begin
                    chk("zero_alu", 64'(memwb_alu_out), 64'd0);
                    chk("zero_load", 64'(memwb_load_out), 64'd0);
                    chk("zero_reg", 64'(memwb_reg_addr_out), 64'd0);
                    chk("zero_wb", 64'(memwb_wb_ctrl_out), 64'd0);
                end
                K_BUB: chk("bubble_wb", 64'(memwb_wb_ctrl_out), 64'd0);
                default: begin
                    chk("memwb_alu", 64'(memwb_alu_out), 64'(rec_alu));
                    if (rec_chk_load) chk("memwb_load", 64'(memwb_load_out), 64'(rec_load));
                    chk("memwb_reg", 64'(memwb_reg_addr_out), 64'(rec_reg));
                    chk("memwb_wb", 64'(memwb_wb_ctrl_out), 64'(rec_wb));
                end
            endcase
        end
    end

    // Present one instruction and advance the model through its whole life.
    task automatic run_op(input logic [31:0] alu, input logic [15:0] sdata, input logic [2:0] rg,
                          input logic [2:0] mc, input logic [1:0] wb, input int delay,
                          input logic [15:0] rdata, input bit ack_on);
        bit rd, wr, memop, illegal, to;
        int s;
        rd      = mc[0];
        wr      = mc[1];
        memop   = rd ^ wr;
        illegal = rd & wr;
        to      = memop && !ack_on;
        s       = !memop ? 0 : (to ? TO + 1 : delay + 2);
        exmem_data_in = {sdata, alu};
        reg_addr_in   = rg;
        mem_ctrl_in   = mc;
        wb_ctrl_in    = wb;
        resp_delay    = delay;
        resp_data     = rdata;
        resp_en       = ack_on;
        exp_addr      = alu[15:0];
        exp_wdata     = sdata;
        exp_we        = wr;
        for (int c = 0; c < s; c++) begin
            exp_stall = 1'b1;
            exp_req   = (c > 0);
            @(posedge clk);
            #1;
            exp_kind = K_BUB;
        end
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        if (to) exp_err = 1'b1;
        @(posedge clk);
        #1;
        mem_ctrl_in  = 3'b000;
        exp_kind     = K_REC;
        rec_alu      = alu;
        rec_load     = (memop && rd && !to) ?
                       (mc[2] ? {{16{rdata[15]}}, rdata} : {16'h0000, rdata}) : 32'h0;
        rec_chk_load = !memop || (rd && !to);
        rec_reg      = rg;
        rec_wb       = {wb[1], wb[0] & ~(illegal | to)};
        if (illegal) exp_err = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        exmem_data_in = '0;
        reg_addr_in   = '0;
        mem_ctrl_in   = '0;
        wb_ctrl_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_req", 64'(bus.mem_req), 64'd0);
        chk("reset_err", 64'(mem_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain ALU op
        run_op(32'h0000_1234, 16'h0, 3'd5, 3'b000, 2'b01, 0, 16'h0, 1'b1);
        $display("alu op: alu=%h reg=%0d wb=%b", memwb_alu_out, memwb_reg_addr_out, memwb_wb_ctrl_out);
        chk("lit_alu", 64'(memwb_alu_out), 64'h1234);
        chk("lit_reg", 64'(memwb_reg_addr_out), 64'd5);
        chk("lit_wb", 64'(memwb_wb_ctrl_out), 64'b01);

        // Sign- and zero-extended loads, ack on first ACCESS cycle
        run_op(32'hABCD_0040, 16'h0, 3'd2, 3'b101, 2'b11, 0, 16'h8001, 1'b1);
        $display("load sx: load=%h wb=%b", memwb_load_out, memwb_wb_ctrl_out);
        chk("lit_load_sx", 64'(memwb_load_out), 64'hFFFF_8001);
        chk("lit_load_wb", 64'(memwb_wb_ctrl_out), 64'b11);
        run_op(32'h0000_0040, 16'h0, 3'd3, 3'b001, 2'b11, 0, 16'h8001, 1'b1);
        $display("load zx: load=%h", memwb_load_out);
        chk("lit_load_zx", 64'(memwb_load_out), 64'h0000_8001);

        // Store with a 3-cycle ack delay
        run_op(32'h0000_0010, 16'hBEEF, 3'd0, 3'b010, 2'b10, 3, 16'h1234, 1'b1);
        $display("store: wb=%b", memwb_wb_ctrl_out);

        // Bubble, then an ALU op with a spurious ack in IDLE
        run_op(32'h0, 16'h0, 3'd0, 3'b000, 2'b00, 0, 16'h0, 1'b1);
        spur = 1'b1;
        run_op(32'h1357_2468, 16'h0, 3'd7, 3'b100, 2'b01, 0, 16'h0, 1'b1);
        spur = 1'b0;
        $display("spurious ack: alu=%h req=%b", memwb_alu_out, bus.mem_req);

        // Load that times out
        run_op(32'h0000_0022, 16'h0, 3'd4, 3'b101, 2'b11, 0, 16'h0, 1'b0);
        $display("timeout: err=%b wb=%b", mem_err, memwb_wb_ctrl_out);
        chk("lit_to_err", 64'(mem_err), 64'd1);
        chk("lit_to_wb", 64'(memwb_wb_ctrl_out), 64'b10);
        run_op(32'h0000_0099, 16'h0, 3'd1, 3'b000, 2'b01, 0, 16'h0, 1'b1);

        // Reset in the middle of an access
        chk_en        = 1'b0;
        resp_en       = 1'b0;
        exmem_data_in = {16'h0, 32'h0000_0080};
        mem_ctrl_in   = 3'b001;
        wb_ctrl_in    = 2'b11;
        reg_addr_in   = 3'd6;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid-access reset: req=%b stall=%b err=%b", bus.mem_req, stall, mem_err);
        chk("rst_req", 64'(bus.mem_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        chk("rst_wb", 64'(memwb_wb_ctrl_out), 64'd0);
        chk("rst_alu", 64'(memwb_alu_out), 64'd0);
        exmem_data_in = '0;
        mem_ctrl_in   = '0;
        wb_ctrl_in    = '0;
        reg_addr_in   = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_kind  = K_ZERO;
        exp_err   = 1'b0;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        chk_en    = 1'b1;

        run_op(32'h0000_0100, 16'h0, 3'd2, 3'b101, 2'b01, 1, 16'h7FFE, 1'b1);
        $display("post-reset load: load=%h", memwb_load_out);
        chk("lit_post_load", 64'(memwb_load_out), 64'h0000_7FFE);
        run_op(32'hCAFE_0001, 16'h0, 3'd3, 3'b000, 2'b01, 0, 16'h0, 1'b1);

        // Illegal read+write
        run_op(32'h0000_0055, 16'h1111, 3'd4, 3'b011, 2'b11, 0, 16'h0, 1'b1);
        $display("illegal: err=%b wb=%b req=%b", mem_err, memwb_wb_ctrl_out, bus.mem_req);
        chk("lit_ill_err", 64'(mem_err), 64'd1);
        chk("lit_ill_wb", 64'(memwb_wb_ctrl_out), 64'b10);
        run_op(32'h0000_0077, 16'h0, 3'd5, 3'b000, 2'b01, 0, 16'h0, 1'b1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
